// File: rtl/demux1to4_32bit_buf_pkg.sv
// demux_pkg: shared widths, channel state and select encodings for the 1-to-4 word demux
package demux_pkg;
  localparam int WIDTH_DEF = 32;
  localparam int NCH = 4;
  typedef enum logic {EMPTY, FULL} chan_state_t;
  localparam logic [1:0] SEL_CH0 = 2'd0;
  localparam logic [1:0] SEL_CH1 = 2'd1;
  localparam logic [1:0] SEL_CH2 = 2'd2;
  localparam logic [1:0] SEL_CH3 = 2'd3;
  function automatic logic [NCH-1:0] sel_onehot(input logic [1:0] s);
    return {s == SEL_CH3, s == SEL_CH2, s == SEL_CH1, s == SEL_CH0};
  endfunction
endpackage

// File: rtl/demux1to4_32bit_buf_if.sv
// demux1to4_32bit_buf_if: producer/consumer bus; cnt0..cnt3 exist only with DEMUX_CHAN_COUNT_EN
interface demux1to4_32bit_buf_if #(parameter int WIDTH = demux_pkg::WIDTH_DEF);
  logic in_valid;
  logic in_ready;
  logic [1:0] in_sel;
  logic [WIDTH-1:0] in_data;
  logic [3:0] out_valid;
  logic [3:0] out_ready;
  logic [WIDTH-1:0] out_data0;
  logic [WIDTH-1:0] out_data1;
  logic [WIDTH-1:0] out_data2;
  logic [WIDTH-1:0] out_data3;
  logic busy;
`ifdef DEMUX_CHAN_COUNT_EN
  logic [7:0] cnt0;
  logic [7:0] cnt1;
  logic [7:0] cnt2;
  logic [7:0] cnt3;
`endif
  modport slave (
    input in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
`ifdef DEMUX_CHAN_COUNT_EN
    , output cnt0, cnt1, cnt2, cnt3
`endif
  );
  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input in_ready, out_valid, out_data0, out_data1, out_data2, out_data3, busy
`ifdef DEMUX_CHAN_COUNT_EN
    , input cnt0, cnt1, cnt2, cnt3
`endif
  );
endinterface

// File: rtl/demux1to4_32bit_buf_chan_buf.sv
// demux_chan_buf: single-entry holding buffer; optional drain counter under DEMUX_CHAN_COUNT_EN
module demux_chan_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic fill,
  input  logic ready,
  input  logic [WIDTH-1:0] din,
  output logic valid,
  output logic [WIDTH-1:0] dout
`ifdef DEMUX_CHAN_COUNT_EN
  , output logic [7:0] cnt
`endif
);
  chan_state_t state, state_nx;
  logic drain;
  always_ff @(posedge clk)
    state <= rst ? EMPTY : state_nx;
  // a fill in the draining cycle wins, keeping the entry full with the new word
  always_comb begin
    drain = (state == FULL) && ready;
    state_nx = fill ? FULL : drain ? EMPTY : state;
  end
  assign valid = state == FULL;
  always_ff @(posedge clk)
    if (rst) dout <= '0;
    else if (fill) dout <= din;
`ifdef DEMUX_CHAN_COUNT_EN
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (drain) cnt <= cnt + 8'd1;
`endif
endmodule

// File: rtl/demux1to4_32bit_buf.sv
// demux1to4_32bit_buf: registered 1-to-4 word demux with per-channel holding buffers
// optional per-channel drain counters cnt0..cnt3 under DEMUX_CHAN_COUNT_EN
module demux1to4_32bit_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic clk,
  input logic rst,
  demux1to4_32bit_buf_if.slave bus
);
  logic [NCH-1:0] valid;
  logic [NCH-1:0] fill;
  logic [WIDTH-1:0] dout [NCH];
  logic acc;
`ifdef DEMUX_CHAN_COUNT_EN
  logic [7:0] cnt [NCH];
`endif
  // ready depends only on registered state and consumer ready, never on in_valid
  always_comb begin
    bus.in_ready = ~valid[bus.in_sel] | bus.out_ready[bus.in_sel];
    acc = bus.in_valid & bus.in_ready;
    fill = acc ? sel_onehot(bus.in_sel) : '0;
  end
  for (genvar k = 0; k < NCH; k++) begin : g_ch
    demux_chan_buf #(.WIDTH(WIDTH)) u_buf (
      .clk(clk),
      .rst(rst),
      .fill(fill[k]),
      .ready(bus.out_ready[k]),
      .din(bus.in_data),
      .valid(valid[k]),
      .dout(dout[k])
`ifdef DEMUX_CHAN_COUNT_EN
      , .cnt(cnt[k])
`endif
    );
  end
  assign bus.out_valid = valid;
  assign bus.busy = |valid;
  assign bus.out_data0 = dout[0];
  assign bus.out_data1 = dout[1];
  assign bus.out_data2 = dout[2];
  assign bus.out_data3 = dout[3];
`ifdef DEMUX_CHAN_COUNT_EN
  assign bus.cnt0 = cnt[0];
  assign bus.cnt1 = cnt[1];
  assign bus.cnt2 = cnt[2];
  assign bus.cnt3 = cnt[3];
`endif
endmodule

// File: tb/tb_demux1to4_32bit_buf.sv
// tb_demux1to4_32bit_buf: directed + random steps against per-channel scoreboard queues
module tb_demux1to4_32bit_buf;
  typedef logic [31:0] q_t[$];
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  demux1to4_32bit_buf_if bus();
  demux1to4_32bit_buf dut (.clk(clk), .rst(rst), .bus(bus));
  q_t sb [4];
  int drains [4];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] od(input int k);
    return k == 0 ? bus.out_data0 : k == 1 ? bus.out_data1 : k == 2 ? bus.out_data2 : bus.out_data3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic [1:0] s, input logic [31:0] d,
                      input logic [3:0] r, input logic rs);
    logic exp_rdy;
    logic [3:0] ev;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_sel = s;
    bus.in_data = d;
    bus.out_ready = r;
    rst = rs;
    #1;
    exp_rdy = (sb[s].size() == 0) || r[s];
    if (!rs) chk("in_ready", {63'd0, bus.in_ready}, {63'd0, exp_rdy});
    @(posedge clk);
    if (rs) begin
      for (int k = 0; k < 4; k++) begin
        sb[k].delete();
        drains[k] = 0;
      end
    end else begin
      for (int k = 0; k < 4; k++)
        if (sb[k].size() != 0 && r[k]) begin
          void'(sb[k].pop_front());
          drains[k]++;
        end
      if (v && exp_rdy) sb[s].push_back(d);
    end
    #1;
    for (int k = 0; k < 4; k++) ev[k] = sb[k].size() != 0;
    chk("out_valid", {60'd0, bus.out_valid}, {60'd0, ev});
    chk("busy", {63'd0, bus.busy}, {63'd0, |ev});
    for (int k = 0; k < 4; k++)
      if (ev[k]) chk($sformatf("out_data%0d", k), {32'd0, od(k)}, {32'd0, sb[k][0]});
  endtask

  initial begin
    bus.in_valid = 0;
    bus.in_sel = 0;
    bus.in_data = 0;
    bus.out_ready = 0;
    step(1, 2'd1, 32'h99, 4'h0, 1);
    step(1, 2'd1, 32'h99, 4'h0, 1);
    step(0, 2'd0, 32'h0, 4'hF, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("reset_data%0d", k), {32'd0, od(k)}, 64'd0);
    chk("reset_in_ready", {63'd0, bus.in_ready}, 64'd1);
    // routing
    step(1, 2'd2, 32'hDEADBEEF, 4'hF, 0);
    chk("route_valid", {60'd0, bus.out_valid}, 64'h4);
    chk("route_data", {32'd0, bus.out_data2}, 64'hDEADBEEF);
    step(0, 2'd0, 32'h0, 4'hF, 0);
    chk("route_drained", {60'd0, bus.out_valid}, 64'h0);
    // backpressure
    step(1, 2'd1, 32'h11, 4'h0, 0);
    step(1, 2'd1, 32'h22, 4'h0, 0);
    chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_hold", {32'd0, bus.out_data1}, 64'h11);
    step(1, 2'd3, 32'h33, 4'h0, 0);
    chk("bp_valid", {60'd0, bus.out_valid}, 64'hA);
    step(0, 2'd0, 32'h0, 4'hF, 0);
    chk("hold_after_drain", {32'd0, bus.out_data1}, 64'h11);
    // drain and fill in one cycle
    step(1, 2'd0, 32'hA, 4'h0, 0);
    step(1, 2'd0, 32'hB, 4'h1, 0);
    chk("df_valid", {63'd0, bus.out_valid[0]}, 64'd1);
    chk("df_data", {32'd0, bus.out_data0}, 64'hB);
    // back-to-back to one channel
    for (int i = 0; i < 8; i++) step(1, 2'd2, $urandom, 4'hF, 0);
    // reset mid-operation
    step(1, 2'd3, 32'h3333, 4'h0, 0);
    step(1, 2'd1, 32'h55, 4'h0, 1);
    chk("mid_reset_valid", {60'd0, bus.out_valid}, 64'h0);
    step(0, 2'd0, 32'h0, 4'h0, 0);
    chk("mid_reset_ch1", {32'd0, bus.out_data1}, 64'h0);
    // 257 drains on channel 2
    for (int i = 0; i < 257; i++) step(1, 2'd2, i, 4'hF, 0);
    step(0, 2'd0, 32'h0, 4'hF, 0);
`ifdef DEMUX_CHAN_COUNT_EN
    chk("cnt0", {56'd0, bus.cnt0}, 64'd0);
    chk("cnt1", {56'd0, bus.cnt1}, 64'd0);
    chk("cnt2", {56'd0, bus.cnt2}, 64'd1);
    chk("cnt3", {56'd0, bus.cnt3}, 64'd0);
`endif
    for (int i = 0; i < 200; i++)
      step(1'($urandom), 2'($urandom), $urandom, 4'($urandom), 0);
`ifdef DEMUX_CHAN_COUNT_EN
    chk("cnt0_rand", {56'd0, bus.cnt0}, 64'(drains[0] % 256));
    chk("cnt1_rand", {56'd0, bus.cnt1}, 64'(drains[1] % 256));
    chk("cnt2_rand", {56'd0, bus.cnt2}, 64'(drains[2] % 256));
    chk("cnt3_rand", {56'd0, bus.cnt3}, 64'(drains[3] % 256));
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
